// File: rtl/ysyx_22040632_RISCV_pkg.sv
// Shared types and defaults for the ysyx_22040632 core control path.
package ysyx_22040632_RISCV_pkg;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT
  } ctrl_state_t;

  typedef enum logic [1:0] {
    HALT_NONE,
    HALT_EBREAK,
    HALT_ILLEGAL,
    HALT_TIMEOUT
  } halt_code_t;

  localparam logic [63:0] RESET_PC_DEFAULT      = 64'h8000_0000;
  localparam int          FETCH_TIMEOUT_DEFAULT = 16;
  localparam int          CNT_W_DEFAULT         = 64;

endpackage

// File: rtl/ysyx_22040632_fetch_timer.sv
// Fetch-wait cycle counter: clear/increment with a terminal-count flag that
// fires on the last permitted wait cycle (count == LIMIT-1).
module ysyx_22040632_fetch_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt;

  // Counter: clear wins over increment; the controller leaves FETCH_WAIT at tc,
  // so the count never needs to exceed LIMIT-1.
  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/ysyx_22040632_core_ctrl.sv
// Multi-cycle instruction sequencer: owns the PC and walks each instruction
// through FETCH_REQ -> FETCH_WAIT -> DECODE -> EXECUTE -> WRITEBACK, halting
// on ebreak, illegal opcode or fetch timeout.
// Optional feature macro: YSYX_22040632_PERF_CNT_EN adds cycle_cnt/instret_cnt.
module ysyx_22040632_core_ctrl
  import ysyx_22040632_RISCV_pkg::*;
#(
  parameter logic [63:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter int          FETCH_TIMEOUT = FETCH_TIMEOUT_DEFAULT
`ifdef YSYX_22040632_PERF_CNT_EN
 ,parameter int          CNT_W         = CNT_W_DEFAULT
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        dec_illegal,
  input  logic        dec_ebreak,
  input  logic        ex_done,
  input  logic [63:0] next_pc,
  output logic        gpr_we,
  output logic [63:0] pc,
  output logic        halted,
  output logic [1:0]  halt_code
`ifdef YSYX_22040632_PERF_CNT_EN
 ,output logic [CNT_W-1:0] cycle_cnt
 ,output logic [CNT_W-1:0] instret_cnt
`endif
);

  ctrl_state_t state, state_n;
  halt_code_t  hcode, hcode_n;
  logic        tmr_clr, tmr_inc, tmr_tc;

  // Timer is cleared while requesting so every FETCH_WAIT starts from zero;
  // it only advances on wait cycles that see no response.
  assign tmr_clr = (state == FETCH_REQ);
  assign tmr_inc = (state == FETCH_WAIT) && !imem_rsp_valid;

  ysyx_22040632_fetch_timer #(
    .LIMIT (FETCH_TIMEOUT)
  ) u_fetch_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .tc    (tmr_tc)
  );

  // State register plus the PC / instruction / halt-code registers it owns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH_REQ;
      hcode <= HALT_NONE;
      pc    <= RESET_PC;
      instr <= 32'h0;
    end else begin
      state <= state_n;
      hcode <= hcode_n;
      if (state == FETCH_WAIT && imem_rsp_valid) instr <= imem_rsp_data;
      if (state == WRITEBACK)                    pc    <= next_pc;
    end
  end

  // Next-state logic; a response in the terminal wait cycle beats the timeout,
  // and ebreak beats illegal when the decoder flags both.
  always_comb begin
    state_n = state;
    hcode_n = hcode;
    case (state)
      FETCH_REQ:  if (imem_req_ready) state_n = FETCH_WAIT;
      FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          state_n = DECODE;
        end else if (tmr_tc) begin
          state_n = HALT;
          hcode_n = HALT_TIMEOUT;
        end
      end
      DECODE: begin
        if (dec_ebreak) begin
          state_n = HALT;
          hcode_n = HALT_EBREAK;
        end else if (dec_illegal) begin
          state_n = HALT;
          hcode_n = HALT_ILLEGAL;
        end else begin
          state_n = EXECUTE;
        end
      end
      EXECUTE:    if (ex_done) state_n = WRITEBACK;
      WRITEBACK:  state_n = FETCH_REQ;
      HALT:       state_n = HALT;
      default:    state_n = FETCH_REQ;
    endcase
  end

  // Moore outputs; request and write strobe live in disjoint states.
  always_comb begin
    imem_req_valid = (state == FETCH_REQ);
    instr_valid    = (state == DECODE) || (state == EXECUTE) || (state == WRITEBACK);
    gpr_we         = (state == WRITEBACK);
    halted         = (state == HALT);
  end

  assign imem_addr = pc;
  assign halt_code = hcode;

`ifdef YSYX_22040632_PERF_CNT_EN
  // Perf counters: cycles while running, retirements on writeback; both wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != HALT)      cycle_cnt   <= cycle_cnt + 1'b1;
      if (state == WRITEBACK) instret_cnt <= instret_cnt + 1'b1;
    end
  end
`endif

endmodule
